// File: rtl/mag_comp_pkg.sv
// rtl/mag_comp_pkg.sv - shared result type, default sizes and merge helper for the magnitude comparator
package mag_comp_pkg;

  localparam int MAG_COMP_WIDTH = 32;
  localparam int MAG_COMP_SLICE = 8;
  localparam int MAG_COMP_CNT_W = 16;

  typedef enum logic [1:0] {
    CMP_EQ,
    CMP_GT,
    CMP_LT
  } cmp_res_t;

  // A decided upper slice always dominates; only an EQ so far lets the lower slice speak.
  function automatic cmp_res_t cmp_merge(input cmp_res_t upper, input cmp_res_t lower);
    return (upper == CMP_EQ) ? lower : upper;
  endfunction

endpackage

// File: rtl/mag_comp_slice.sv
// rtl/mag_comp_slice.sv - one combinational comparator stage: slice compare merged with the upstream result
module mag_comp_slice
  import mag_comp_pkg::*;
#(
  parameter int SLICE = MAG_COMP_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             flip_msb,
  input  cmp_res_t         res_in,
  output cmp_res_t         res_out
);

  logic [SLICE-1:0] a_m;
  logic [SLICE-1:0] b_m;
  cmp_res_t         local_res;

  always_comb begin
    a_m       = a;
    b_m       = b;
    local_res = CMP_EQ;
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    if (flip_msb) begin
      a_m[SLICE-1] = ~a[SLICE-1];
      b_m[SLICE-1] = ~b[SLICE-1];
    end
    if (a_m > b_m) begin
      local_res = CMP_GT;
    end else if (a_m < b_m) begin
      local_res = CMP_LT;
    end
    res_out = cmp_merge(res_in, local_res);
  end

endmodule

// File: rtl/mag_comp_pipe.sv
// rtl/mag_comp_pipe.sv - MSB-first pipelined magnitude comparator with result tallies; MAG_COMP_SIGNED_EN enables signed compares
module mag_comp_pipe
  import mag_comp_pkg::*;
#(
  parameter int WIDTH = MAG_COMP_WIDTH,
  parameter int SLICE = MAG_COMP_SLICE,
  parameter int CNT_W = MAG_COMP_CNT_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Signed,
  input  logic             InValid,
  output logic             InReady,
  output logic             Gt,
  output logic             Lt,
  output logic             Eq,
  output logic             OutValid,
  input  logic             OutReady,
  input  logic             CntClear,
  output logic [CNT_W-1:0] GtCount,
  output logic [CNT_W-1:0] LtCount,
  output logic [CNT_W-1:0] EqCount
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              advance;
  logic              flip0;
  logic [NSLICE-1:0] vld_q;
  logic [WIDTH-1:0]  a_q    [NSLICE];
  logic [WIDTH-1:0]  b_q    [NSLICE];
  cmp_res_t          res_q  [NSLICE];
  cmp_res_t          res_nx [NSLICE];
  logic [CNT_W-1:0]  gt_cnt;
  logic [CNT_W-1:0]  lt_cnt;
  logic [CNT_W-1:0]  eq_cnt;

  assign advance = !OutValid || OutReady;
  assign InReady = advance;

`ifdef MAG_COMP_SIGNED_EN
  logic sgn_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sgn_q <= 1'b0;
    end else if (advance) begin
      sgn_q <= Signed;
    end
  end

  assign flip0 = sgn_q;
`else
  logic unused_signed;

  assign unused_signed = Signed;
  assign flip0         = 1'b0;
`endif

  // Stage k always compares the top slice of its operand copy; operands shift up a slice per stage.
  for (genvar k = 0; k < NSLICE; k++) begin : g_stage
    mag_comp_slice #(
      .SLICE(SLICE)
    ) u_slice (
      .a        (a_q[k][WIDTH-1 -: SLICE]),
      .b        (b_q[k][WIDTH-1 -: SLICE]),
      .flip_msb ((k == 0) ? flip0 : 1'b0),
      .res_in   (res_q[k]),
      .res_out  (res_nx[k])
    );
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      vld_q    <= '0;
      OutValid <= 1'b0;
      Gt       <= 1'b0;
      Lt       <= 1'b0;
      Eq       <= 1'b0;
      for (int k = 0; k < NSLICE; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= CMP_EQ;
      end
    end else if (advance) begin
      vld_q[0] <= InValid;
      a_q[0]   <= A;
      b_q[0]   <= B;
      res_q[0] <= CMP_EQ;
      for (int k = 1; k < NSLICE; k++) begin
        vld_q[k] <= vld_q[k-1];
        a_q[k]   <= a_q[k-1] << SLICE;
        b_q[k]   <= b_q[k-1] << SLICE;
        res_q[k] <= res_nx[k-1];
      end
      OutValid <= vld_q[NSLICE-1];
      Gt       <= vld_q[NSLICE-1] && (res_nx[NSLICE-1] == CMP_GT);
      Lt       <= vld_q[NSLICE-1] && (res_nx[NSLICE-1] == CMP_LT);
      Eq       <= vld_q[NSLICE-1] && (res_nx[NSLICE-1] == CMP_EQ);
    end
  end

  // Clear takes priority over a handshake landing on the same edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      gt_cnt <= '0;
      lt_cnt <= '0;
      eq_cnt <= '0;
    end else if (CntClear) begin
      gt_cnt <= '0;
      lt_cnt <= '0;
      eq_cnt <= '0;
    end else if (OutValid && OutReady) begin
      if (Gt && (gt_cnt != '1)) begin
        gt_cnt <= gt_cnt + CNT_ONE;
      end
      if (Lt && (lt_cnt != '1)) begin
        lt_cnt <= lt_cnt + CNT_ONE;
      end
      if (Eq && (eq_cnt != '1)) begin
        eq_cnt <= eq_cnt + CNT_ONE;
      end
    end
  end

  assign GtCount = gt_cnt;
  assign LtCount = lt_cnt;
  assign EqCount = eq_cnt;

endmodule

// File: tb/tb_mag_comp_pipe.sv
// tb/tb_mag_comp_pipe.sv - scoreboard bench for mag_comp_pipe; honours MAG_COMP_SIGNED_EN
module tb_mag_comp_pipe;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int CNT_W  = 16;
  localparam int NSLICE = WIDTH / SLICE;
`ifdef MAG_COMP_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             Signed = 1'b0;
  logic             InValid = 1'b0;
  logic             InReady;
  logic             Gt, Lt, Eq;
  logic             OutValid;
  logic             OutReady = 1'b1;
  logic             CntClear = 1'b0;
  logic [CNT_W-1:0] GtCount, LtCount, EqCount;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [2:0]       exp_q[$];
  logic [CNT_W-1:0] m_gt = '0;
  logic [CNT_W-1:0] m_lt = '0;
  logic [CNT_W-1:0] m_eq = '0;

  mag_comp_pipe #(
    .WIDTH(WIDTH),
    .SLICE(SLICE),
    .CNT_W(CNT_W)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .A       (A),
    .B       (B),
    .Signed  (Signed),
    .InValid (InValid),
    .InReady (InReady),
    .Gt      (Gt),
    .Lt      (Lt),
    .Eq      (Eq),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .CntClear(CntClear),
    .GtCount (GtCount),
    .LtCount (LtCount),
    .EqCount (EqCount)
  );

  always #5 Clock = ~Clock;

  initial forever begin
    @(posedge Clock);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected {Gt,Lt,Eq} straight from numeric order of the operands.
  function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    longint va, vb;
    if (s && SIGNED_EN) begin
      va = longint'($signed(a));
      vb = longint'($signed(b));
    end else begin
      va = longint'({32'h0, a});
      vb = longint'({32'h0, b});
    end
    if (va > vb) return 3'b100;
    if (va < vb) return 3'b010;
    return 3'b001;
  endfunction

  // Monitor / scoreboard: everything sampled at the falling edge.
  initial begin
    logic       prev_hold;
    logic [3:0] prev_out;
    logic [2:0] exp;
    logic       hs;
    prev_hold = 1'b0;
    prev_out  = '0;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        exp_q.delete();
        m_gt = '0;
        m_lt = '0;
        m_eq = '0;
        prev_hold = 1'b0;
      end else begin
        hs = OutValid && OutReady;
        check("in_ready", InReady, !OutValid || OutReady);
        if (!OutValid) check("idle_flags", {Gt, Lt, Eq}, 3'b000);
        if (prev_hold) check("stall_hold", {OutValid, Gt, Lt, Eq}, prev_out);
        check("gt_count", GtCount, m_gt);
        check("lt_count", LtCount, m_lt);
        check("eq_count", EqCount, m_eq);
        exp = 3'b000;
        if (hs) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", OutValid, 1'b0);
          end else begin
            exp = exp_q.pop_front();
            check("result", {Gt, Lt, Eq}, exp);
          end
        end
        if (CntClear) begin
          m_gt = '0;
          m_lt = '0;
          m_eq = '0;
        end else begin
          if (exp[2] && m_gt != '1) m_gt++;
          if (exp[1] && m_lt != '1) m_lt++;
          if (exp[0] && m_eq != '1) m_eq++;
        end
        prev_hold = OutValid && !OutReady;
        prev_out  = {OutValid, Gt, Lt, Eq};
        if (InValid && InReady) exp_q.push_back(ref_cmp(A, B, Signed));
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    int   g;
    logic rdy;
    A       = a;
    B       = b;
    Signed  = s;
    InValid = 1'b1;
    g       = 0;
    do begin
      @(negedge Clock);
      rdy = InReady;
      @(posedge Clock);
      #1;
      g++;
    end while (!rdy && g < 100);
    if (!rdy) check("send_timeout", rdy, 1'b1);
    InValid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int g;
    g = 0;
    while (!OutValid && g < 50) begin
      @(posedge Clock);
      #1;
      g++;
    end
    check(name, OutValid, 1'b1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || OutValid) && g < 300) begin
      @(posedge Clock);
      #1;
      g++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_out_valid", OutValid, 1'b0);
    check("rst_flags", {Gt, Lt, Eq}, 3'b000);
    check("rst_counts", {GtCount, LtCount, EqCount}, 48'h0);
    check("rst_in_ready", InReady, 1'b1);
    Reset = 1'b0;
    check("post_rst_in_ready", InReady, 1'b1);
    @(posedge Clock);
    #1;

    // Equal operands, exact latency, first tally.
    A = 32'h12345678; B = 32'h12345678; Signed = 1'b0; InValid = 1'b1;
    @(posedge Clock);
    #1;
    InValid = 1'b0;
    n = 0;
    while (!OutValid && n < 20) begin
      @(posedge Clock);
      #1;
      n++;
    end
    check("latency", n, NSLICE);
    check("eq_flag", {Gt, Lt, Eq}, 3'b001);
    @(posedge Clock);
    #1;
    check("eq_count_one", EqCount, 16'd1);

    // Sign-bit operand, unsigned then signed.
    send(32'h80000000, 32'h00000001, 1'b0);
    send(32'h80000000, 32'h00000001, 1'b1);
    wait_valid("wait_sign");
    check("unsigned_msb", {Gt, Lt, Eq}, 3'b100);
    @(posedge Clock);
    #1;
    check("signed_msb", {OutValid, Gt, Lt, Eq}, SIGNED_EN ? 4'b1010 : 4'b1100);
    drain();

    // Back-to-back results emerge on consecutive cycles.
    send(32'h01000000, 32'h00FFFFFF, 1'b0);
    send(32'h000000FF, 32'h00000100, 1'b0);
    wait_valid("wait_b2b");
    check("b2b_first", {Gt, Lt, Eq}, 3'b100);
    @(posedge Clock);
    #1;
    check("b2b_second", {OutValid, Gt, Lt, Eq}, 4'b1010);
    drain();

    // Stall with a full pipeline, then release.
    for (int i = 0; i < NSLICE + 1; i++) send($urandom, $urandom, 1'(i));
    check("stall_full", OutValid, 1'b1);
    OutReady = 1'b0;
    A = 32'hCAFE0000; B = 32'hCAFE0001; InValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", InReady, 1'b0);
      @(posedge Clock);
      #1;
    end
    OutReady = 1'b1;
    @(posedge Clock);
    #1;
    InValid = 1'b0;
    drain();

    // Randomized traffic with random backpressure and occasional clears.
    for (int i = 0; i < 600; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (32'h1 << $urandom_range(0, 31));
        2: rb = $urandom;
        default: begin
          ra = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h7FFFFFFF;
          rb = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h00000000;
        end
      endcase
      A        = ra;
      B        = rb;
      Signed   = 1'($urandom_range(0, 1));
      InValid  = ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 3) != 0);
      CntClear = ($urandom_range(0, 99) == 0);
      @(posedge Clock);
      #1;
    end
    InValid  = 1'b0;
    CntClear = 1'b0;
    OutReady = 1'b1;
    drain();

    // Saturation near the top of the equal tally.
    force dut.eq_cnt = 16'hFFFE;
    m_eq = 16'hFFFE;
    @(posedge Clock);
    #1;
    release dut.eq_cnt;
    check("eq_preload", EqCount, 16'hFFFE);
    for (int i = 0; i < 3; i++) send(32'h0BADF00D, 32'h0BADF00D, 1'b0);
    drain();
    check("eq_saturated", EqCount, 16'hFFFF);

    // Clear coincident with a handshake wins.
    send(32'h00000042, 32'h00000042, 1'b0);
    wait_valid("wait_clear");
    CntClear = 1'b1;
    @(posedge Clock);
    #1;
    CntClear = 1'b0;
    check("clear_wins", EqCount, 16'h0000);
    drain();

    // Reset with three operands in flight.
    send(32'h00000005, 32'h00000003, 1'b0);
    send(32'h00000003, 32'h00000005, 1'b0);
    send(32'h00000007, 32'h00000007, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    check("rst_mid_valid", OutValid, 1'b0);
    check("rst_mid_flags", {Gt, Lt, Eq}, 3'b000);
    check("rst_mid_counts", {GtCount, LtCount, EqCount}, 48'h0);
    check("rst_mid_in_ready", InReady, 1'b1);
    @(posedge Clock);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    check("rst_rel_in_ready", InReady, 1'b1);
    for (int i = 0; i < 2 * NSLICE; i++) begin
      @(posedge Clock);
      #1;
      check("rst_no_ghost", OutValid, 1'b0);
    end
    send(32'hFFFFFFFF, 32'h00000000, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mag_comp_pipe.md
MAG_COMP_PIPE -- requirements
Module: mag_comp_pipe

Interface
REQ-001 Parameter WIDTH, 32, operand width in bits; SHALL be a multiple of SLICE.
REQ-002 Parameter SLICE, 8, bits compared per pipeline stage; NSLICE = WIDTH/SLICE stages.
REQ-003 Parameter CNT_W, 16, width of each result counter.
REQ-004 Clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 A  input  WIDTH  operand A.
REQ-007 B  input  WIDTH  operand B.
REQ-008 Signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with A/B.
REQ-009 InValid  input  1  A/B/Signed valid.
REQ-010 InReady  output  1  block accepts operands this cycle.
REQ-011 Gt, Lt, Eq  output  1 each  registered result flags; exactly one high while OutValid=1.
REQ-012 OutValid  output  1  result flags valid.
REQ-013 OutReady  input  1  downstream accepts result.
REQ-014 CntClear  input  1  synchronous clear of all counters.
REQ-015 GtCount, LtCount, EqCount  output  CNT_W each  saturating result tallies.

Function
REQ-016 Comparison SHALL be MSB-first: stage 0 compares slice [WIDTH-1 -: SLICE], stage k compares the k-th slice below it.
REQ-017 Each stage SHALL carry a partial result {EQ, GT, LT}; a stage SHALL overwrite the result only if the incoming partial result is EQ.
REQ-018 With Signed=1 and MAG_COMP_SIGNED_EN defined, stage 0 SHALL invert bit WIDTH-1 of both operands before comparing.
REQ-019 Latency SHALL be exactly NSLICE cycles from accepted input (InValid && InReady) to OutValid, absent stalls.
REQ-020 Pipeline SHALL advance as a whole when advance = !OutValid || OutReady; otherwise every stage holds.
REQ-021 InReady SHALL equal advance (combinational); input accepted only when InValid && InReady.
REQ-022 Bubbles SHALL propagate as invalid stages; no bubble collapsing.
REQ-023 Gt/Lt/Eq and OutValid SHALL hold stable while OutValid && !OutReady.
REQ-024 Throughput SHALL be one result per cycle with OutReady held high.
REQ-025 On output handshake (OutValid && OutReady) the counter matching the result SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-026 CntClear SHALL zero all three counters next cycle; clear SHALL win over a simultaneous increment.
REQ-027 When OutValid=0, Gt/Lt/Eq SHALL be 0.

Reset
REQ-028 While Reset is high: all stage valids, OutValid, Gt, Lt, Eq and all counters SHALL be 0.
REQ-029 Reset mid-operation SHALL discard all in-flight operands; no result SHALL emerge from them.
REQ-030 InReady SHALL be 1 during and immediately after reset.

Configuration
REQ-031 Macro MAG_COMP_SIGNED_EN: defined, Signed selects signed/unsigned per transaction; undefined, Signed SHALL be ignored and all compares unsigned, with port list unchanged.

Structure
REQ-032 Package mag_comp_pkg SHALL hold enum cmp_res_t {CMP_EQ, CMP_GT, CMP_LT} and default parameter constants.
REQ-033 Sub-module mag_comp_slice SHALL implement one combinational stage: slice compare plus merge with incoming cmp_res_t; mag_comp_pipe instantiates NSLICE copies with registers between.

Verification (WIDTH=32, SLICE=8, CNT_W=16, latency 4)
REQ-034 A=0x12345678, B=0x12345678, Signed=0, OutReady=1 -> Eq=1 four cycles later; EqCount=1.
REQ-035 A=0x80000000, B=0x00000001: Signed=0 -> Gt=1; Signed=1 -> Lt=1 (with MAG_COMP_SIGNED_EN), Gt=1 (without).
REQ-036 Back-to-back A=0x01000000/B=0x00FFFFFF then A=0x000000FF/B=0x00000100 -> Gt then Lt on consecutive cycles.
REQ-037 OutReady=0 for 3 cycles with pipeline full -> InReady=0, outputs frozen, no counter change; on release results drain in order, none lost or duplicated.
REQ-038 EqCount forced to 0xFFFE, three equal results -> EqCount 0xFFFF, held; CntClear coincident with a handshake -> 0x0000.
REQ-039 Reset asserted with 3 transactions in flight -> all outputs 0 immediately; after release no OutValid until a new input is accepted.
